// File: rtl/risc_pkg.sv
// Shared types and helpers for the core's memory path: access sizes, the data-memory
// arbiter state encoding and the alignment check also used by the LSU.
package risc_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } dmem_arb_state_t;

  function automatic logic is_misaligned(mem_size_t size, logic [1:0] addr_lo);
    case (size)
      HALF_WORD: return addr_lo[0];
      WORD:      return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(mem_size_t size);
    case (size)
      HALF_WORD: return 3'd2;
      WORD:      return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port that was
// not granted last. Purely combinational; the history bit lives in the caller.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the LSU (port 0) and the debug/DMA port
// (port 1): one transaction in flight, error requests are answered without touching memory.
module dmem_arbiter
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_PORTS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            m_req,
  output logic [1:0]            m_gnt,
  input  logic [1:0]            m_wr_en,
  input  mem_size_t [1:0]       m_size,
  input  logic [1:0][31:0]      m_addr,
  input  logic [1:0][31:0]      m_wdata,
  input  logic [1:0]            m_zext,
  output logic [1:0]            m_rvalid,
  output logic [31:0]           m_rdata,
  output logic                  m_err,
  output logic                  dmem_req,
  output logic                  dmem_wr_en,
  output mem_size_t             dmem_data_size,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wr_data,
  output logic                  dmem_zero_extend,
  input  logic [31:0]           dmem_rd_data
);

  if (NUM_PORTS != 2) begin : g_bad_ports
    $error("dmem_arbiter supports exactly two ports");
  end

  dmem_arb_state_t state;
  logic            last_gnt;
  logic            port_q;
  logic [1:0]      rvalid_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [1:0]      arb_gnt;
  logic            gnt_port;
  mem_size_t       sel_size;
  logic [31:0]     sel_addr;
  logic [32:0]     end_addr;
  logic            req_err;

  rr_arbiter2 u_rr (
    .req      (m_req),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt)
  );

  assign gnt_port = arb_gnt[1];

  always_comb begin
    sel_size = m_size[gnt_port];
    sel_addr = m_addr[gnt_port];
    end_addr = {1'b0, sel_addr} + {30'd0, size_bytes(sel_size)} - 33'd1;
    req_err  = !(sel_size inside {BYTE, HALF_WORD, WORD})
               || is_misaligned(sel_size, sel_addr[1:0])
               || ((end_addr >> ADDR_WIDTH) != 33'd0);
  end

  // Reset silences the response side immediately, so a RESP cut short by reset never
  // shows rvalid to the master.
  assign m_gnt    = (rst_n && state == ARB_IDLE) ? arb_gnt : 2'b00;
  assign m_rvalid = rst_n ? rvalid_q : 2'b00;
  assign m_rdata  = rst_n ? rdata_q : 32'd0;
  assign m_err    = rst_n ? err_q : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ARB_IDLE;
      last_gnt         <= 1'b1;
      port_q           <= 1'b0;
      rvalid_q         <= 2'b00;
      rdata_q          <= 32'd0;
      err_q            <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_wr_en       <= 1'b0;
      dmem_data_size   <= BYTE;
      dmem_addr        <= 32'd0;
      dmem_wr_data     <= 32'd0;
      dmem_zero_extend <= 1'b0;
    end else begin
      rvalid_q         <= 2'b00;
      rdata_q          <= 32'd0;
      err_q            <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_wr_en       <= 1'b0;
      dmem_data_size   <= BYTE;
      dmem_addr        <= 32'd0;
      dmem_wr_data     <= 32'd0;
      dmem_zero_extend <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (arb_gnt != 2'b00) begin
            port_q   <= gnt_port;
            last_gnt <= gnt_port;
            if (req_err) begin
              state    <= ARB_RESP;
              rvalid_q <= arb_gnt;
              err_q    <= 1'b1;
            end else begin
              // The dmem_* registers double as the request latch for the ACCESS cycle.
              state            <= ARB_ACCESS;
              dmem_req         <= 1'b1;
              dmem_wr_en       <= m_wr_en[gnt_port];
              dmem_data_size   <= sel_size;
              dmem_addr        <= sel_addr;
              dmem_wr_data     <= m_wdata[gnt_port];
              dmem_zero_extend <= m_zext[gnt_port];
            end
          end
        end
        ARB_ACCESS: begin
          state    <= ARB_RESP;
          rvalid_q <= port_q ? 2'b10 : 2'b01;
          rdata_q  <= dmem_wr_en ? 32'd0 : dmem_rd_data;
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule
